// File: rtl/mdu_pkg.sv
// Shared types for the iterative multiply/divide sequencer.
// Optional divide-by-zero early exit is selected with MDU_DIVZERO_EN.
package mdu_pkg;

   localparam int MDU_WIDTH = 32;

   typedef enum logic [1:0] {
      MULT  = 2'd0,
      MULTU = 2'd1,
      DIV   = 2'd2,
      DIVU  = 2'd3
   } mdu_op_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      FIX   = 2'd2,
      WRITE = 2'd3
   } mdu_state_t;

   function automatic logic op_is_div(mdu_op_t o);
      return (o == DIV) || (o == DIVU);
   endfunction

   function automatic logic op_is_signed(mdu_op_t o);
      return (o == MULT) || (o == DIV);
   endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// Core-side bundle of the multiply/divide sequencer.
// divz exists only when MDU_DIVZERO_EN is defined.
interface mdu_ctrl_if
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH
);

   logic               start;
   mdu_op_t            op;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic               hl_rd;
   logic               busy;
   logic               stall;
   logic               hl_we;
   logic [2*WIDTH-1:0] hl_wd;
   logic               done;
`ifdef MDU_DIVZERO_EN
   logic               divz;

   modport master (
      output start, op, a, b, hl_rd,
      input  busy, stall, hl_we, hl_wd, done, divz
   );

   modport slave (
      input  start, op, a, b, hl_rd,
      output busy, stall, hl_we, hl_wd, done, divz
   );
`else
   modport master (
      output start, op, a, b, hl_rd,
      input  busy, stall, hl_we, hl_wd, done
   );

   modport slave (
      input  start, op, a, b, hl_rd,
      output busy, stall, hl_we, hl_wd, done
   );
`endif

endinterface

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate used to restore result signs.
module mdu_sign_fix #(
   parameter int N = 32
) (
   input  logic         neg,
   input  logic [N-1:0] d,
   output logic [N-1:0] q
);

   assign q = neg ? (~d + N'(1)) : d;

endmodule

// File: rtl/mdu_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer feeding the HI/LO write port.
// MDU_DIVZERO_EN: divide by zero skips straight to WRITE and pulses divz.
module mdu_ctrl
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH
) (
   input  logic     clk,
   input  logic     reset_n,
   mdu_ctrl_if.slave bus
);

   localparam int W2 = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] S_IDLE  = IDLE;
   localparam logic [1:0] S_CALC  = CALC;
   localparam logic [1:0] S_FIX   = FIX;
   localparam logic [1:0] S_WRITE = WRITE;

   logic [1:0]       state;
   logic [CW-1:0]    count;
   logic [W2-1:0]    acc;
   logic [W2-1:0]    mcand;
   logic [WIDTH-1:0] opb;
   logic             is_dv;
   logic             neg_q;
   logic             neg_r;
   logic             dz;
   logic [W2-1:0]    wd_q;

   logic             dv_in;
   logic             sg_in;
   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;

   logic [WIDTH:0]   rs;
   logic [WIDTH:0]   rd;
   logic             qbit;
   logic [W2-1:0]    div_next;
   logic [W2-1:0]    mul_next;

   logic [W2-1:0]    prod_f;
   logic [WIDTH-1:0] quo_f;
   logic [WIDTH-1:0] rem_f;

   always_comb begin
      dv_in = op_is_div(bus.op);
      sg_in = op_is_signed(bus.op);
      mag_a = bus.a;
      mag_b = bus.b;
      if (sg_in && bus.a[WIDTH-1]) mag_a = ~bus.a + WIDTH'(1);
      if (sg_in && bus.b[WIDTH-1]) mag_b = ~bus.b + WIDTH'(1);
   end

   // Restoring step: partial remainder needs one guard bit.
   always_comb begin
      rs       = {acc[W2-1:WIDTH], acc[WIDTH-1]};
      rd       = rs - {1'b0, opb};
      qbit     = (rs >= {1'b0, opb});
      div_next = {qbit ? rd[WIDTH-1:0] : rs[WIDTH-1:0],
                  acc[WIDTH-2:0], qbit};
      mul_next = opb[0] ? (acc + mcand) : acc;
   end

   mdu_sign_fix #(.N(W2)) u_prod (
      .neg (neg_q),
      .d   (acc),
      .q   (prod_f)
   );

   mdu_sign_fix #(.N(WIDTH)) u_quo (
      .neg (neg_q),
      .d   (acc[WIDTH-1:0]),
      .q   (quo_f)
   );

   mdu_sign_fix #(.N(WIDTH)) u_rem (
      .neg (neg_r),
      .d   (acc[W2-1:WIDTH]),
      .q   (rem_f)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
         count <= '0;
         acc   <= '0;
         mcand <= '0;
         opb   <= '0;
         is_dv <= 1'b0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         dz    <= 1'b0;
         wd_q  <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (bus.start) begin
                  is_dv <= dv_in;
                  neg_q <= sg_in & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                  neg_r <= sg_in & bus.a[WIDTH-1];
                  count <= '0;
                  opb   <= mag_b;
                  mcand <= W2'(mag_a);
                  acc   <= dv_in ? W2'(mag_a) : '0;
                  dz    <= 1'b0;
                  state <= S_CALC;
`ifdef MDU_DIVZERO_EN
                  if (dv_in && (bus.b == '0)) begin
                     wd_q  <= {bus.a, {WIDTH{1'b1}}};
                     dz    <= 1'b1;
                     state <= S_WRITE;
                  end
`endif
               end
            end
            S_CALC: begin
               acc   <= is_dv ? div_next : mul_next;
               mcand <= {mcand[W2-2:0], 1'b0};
               opb   <= is_dv ? opb : (opb >> 1);
               count <= count + CW'(1);
               if (count == CW'(WIDTH - 1)) state <= S_FIX;
            end
            S_FIX: begin
               wd_q  <= is_dv ? {rem_f, quo_f} : prod_f;
               state <= S_WRITE;
            end
            S_WRITE: begin
               dz    <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy  = (state != S_IDLE);
   assign bus.stall = bus.busy & (bus.hl_rd | bus.start);
   assign bus.hl_we = (state == S_WRITE);
   assign bus.done  = bus.hl_we;
   assign bus.hl_wd = wd_q;
`ifdef MDU_DIVZERO_EN
   assign bus.divz  = bus.hl_we & dz;
`endif

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: transaction-level model plus directed cases.
module tb_mdu_ctrl;
   import mdu_pkg::*;

   localparam int W = 32;
`ifdef MDU_DIVZERO_EN
   localparam int DZLAT = 1;
`else
   localparam int DZLAT = W + 2;
`endif

   logic clk = 1'b0;
   logic reset_n = 1'b1;

   mdu_ctrl_if #(.WIDTH(W)) bus ();

   mdu_ctrl #(.WIDTH(W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int errs = 0;
   int checks = 0;
   int nwrites = 0;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         if (errs < 40)
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] ref_res(mdu_op_t o, logic [31:0] x,
                                           logic [31:0] y);
      longint sx, sy, sq, sr;
      logic [63:0] ux, uy, uq, ur, sp;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'd0, x};
      uy = {32'd0, y};
      if (((o == DIV) || (o == DIVU)) && (y == 32'd0))
         return {x, 32'hFFFF_FFFF};
      case (o)
         MULT: begin
            sp = 64'(sx * sy);
            return sp;
         end
         MULTU: return ux * uy;
         DIV: begin
            sq = sx / sy;
            sr = sx % sy;
            return {sr[31:0], sq[31:0]};
         end
         default: begin
            uq = ux / uy;
            ur = ux % uy;
            return {ur[31:0], uq[31:0]};
         end
      endcase
   endfunction

   function automatic int ref_lat(mdu_op_t o, logic [31:0] y);
      if (((o == DIV) || (o == DIVU)) && (y == 32'd0)) return DZLAT;
      return W + 2;
   endfunction

   // m_left: cycles until the write lands; 0 means idle
   int          m_left = 0;
   logic [63:0] m_res = '0;
   logic [63:0] m_last = '0;
   logic        m_dz = 1'b0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_left <= 0;
         m_last <= '0;
         m_dz   <= 1'b0;
      end else if (m_left == 0) begin
         if (bus.start) begin
            m_res  <= ref_res(bus.op, bus.a, bus.b);
            m_left <= ref_lat(bus.op, bus.b);
            m_dz   <= (ref_lat(bus.op, bus.b) == 1);
         end
      end else begin
         m_left <= m_left - 1;
         if (m_left == 1) m_last <= m_res;
      end
   end

   always @(negedge clk) begin
      logic eb, ew;
      eb = (m_left != 0);
      ew = (m_left == 1);
      chk("busy", 64'(bus.busy), 64'(eb));
      chk("stall", 64'(bus.stall), 64'(eb & (bus.hl_rd | bus.start)));
      chk("hl_we", 64'(bus.hl_we), 64'(ew));
      chk("done", 64'(bus.done), 64'(ew));
      chk("hl_wd", bus.hl_wd, ew ? m_res : m_last);
`ifdef MDU_DIVZERO_EN
      chk("divz", 64'(bus.divz), 64'(ew & m_dz));
`endif
      if (bus.hl_we === 1'b1) nwrites++;
   end

   task automatic idle_inputs();
      bus.start = 1'b0;
      bus.op    = MULT;
      bus.a     = '0;
      bus.b     = '0;
      bus.hl_rd = 1'b0;
   endtask

   task automatic run_op(string name, mdu_op_t o, logic [31:0] x,
                         logic [31:0] y, logic [63:0] exp, int exp_lat);
      int n;
      @(posedge clk);
      #2;
      bus.start = 1'b1;
      bus.op    = o;
      bus.a     = x;
      bus.b     = y;
      @(posedge clk);
      #2;
      bus.start = 1'b0;
      n = 0;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         if (bus.hl_we === 1'b1) begin
            n = i;
            break;
         end
      end
      chk({name, "_lat"}, 64'(n), 64'(exp_lat));
      chk({name, "_wd"}, bus.hl_wd, exp);
      @(negedge clk);
      chk({name, "_idle"}, 64'(bus.busy), 64'd0);
      chk({name, "_hold"}, bus.hl_wd, exp);
   endtask

   initial begin
      int we_cnt;
      logic [31:0] ra, rb;
      mdu_op_t ro;

      idle_inputs();
      #1 reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #2 reset_n = 1'b1;
      @(negedge clk);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_we", 64'(bus.hl_we), 64'd0);
      chk("rst_wd", bus.hl_wd, 64'd0);

      chk("pin_mult", ref_res(MULT, 32'hFFFF_FFFD, 32'd5),
          64'hFFFF_FFFF_FFFF_FFF1);
      chk("pin_div", ref_res(DIV, 32'hFFFF_FFF9, 32'd2),
          64'hFFFF_FFFF_FFFF_FFFD);
      chk("pin_divu", ref_res(DIVU, 32'd100, 32'd7),
          64'h0000_0002_0000_000E);

      run_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
             64'hFFFF_FFFE_0000_0001, 34);
      run_op("mult_neg", MULT, 32'hFFFF_FFFD, 32'd5,
             64'hFFFF_FFFF_FFFF_FFF1, 34);
      run_op("div_neg", DIV, 32'hFFFF_FFF9, 32'd2,
             64'hFFFF_FFFF_FFFF_FFFD, 34);
      run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF,
             64'h0000_0000_8000_0000, 34);
      run_op("divu", DIVU, 32'd100, 32'd7,
             64'h0000_0002_0000_000E, 34);
      run_op("mult_min", MULT, 32'h8000_0000, 32'h8000_0000,
             64'h4000_0000_0000_0000, 34);
      run_op("div_negb", DIV, 32'd7, 32'hFFFF_FFFE,
             64'h0000_0001_FFFF_FFFD, 34);
      run_op("divu_z", DIVU, 32'h0000_1234, 32'd0,
             64'h0000_1234_FFFF_FFFF, DZLAT);

      // Retries while busy must neither restart nor add a write
      @(posedge clk);
      #2;
      bus.start = 1'b1;
      bus.op    = MULTU;
      bus.a     = 32'd6;
      bus.b     = 32'd7;
      @(posedge clk);
      #2;
      we_cnt = 0;
      for (int n = 1; n <= 60; n++) begin
         bus.start = (n == 5) || (n == 33) || (n == 34);
         bus.hl_rd = (n == 10);
         @(negedge clk);
         if (n == 5 || n == 10 || n == 33)
            chk($sformatf("retry_stall%0d", n), 64'(bus.stall), 64'd1);
         if (bus.hl_we === 1'b1) we_cnt++;
         @(posedge clk);
         #2;
      end
      idle_inputs();
      chk("retry_writes", 64'(we_cnt), 64'd1);
      chk("retry_wd", bus.hl_wd, 64'd42);

      // Reset in the middle of CALC
      bus.start = 1'b1;
      bus.op    = DIVU;
      bus.a     = 32'd1000;
      bus.b     = 32'd3;
      @(posedge clk);
      #2;
      bus.start = 1'b0;
      repeat (16) @(posedge clk);
      #2;
      bus.hl_rd = 1'b1;
      reset_n   = 1'b0;
      #1;
      chk("rst_mid_busy", 64'(bus.busy), 64'd0);
      chk("rst_mid_stall", 64'(bus.stall), 64'd0);
      chk("rst_mid_we", 64'(bus.hl_we), 64'd0);
      chk("rst_mid_wd", bus.hl_wd, 64'd0);
      @(posedge clk);
      #2;
      reset_n   = 1'b1;
      bus.hl_rd = 1'b0;
      we_cnt = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (bus.hl_we === 1'b1) we_cnt++;
      end
      chk("rst_mid_nowrite", 64'(we_cnt), 64'd0);
      run_op("after_rst", DIVU, 32'd1000, 32'd3,
             64'h0000_0001_0000_014D, 34);

      // Randomized traffic, checked cycle by cycle against the model
      nwrites = 0;
      for (int c = 0; c < 8000; c++) begin
         @(posedge clk);
         #2;
         ro = mdu_op_t'($urandom_range(0, 3));
         case ($urandom_range(0, 5))
            0: ra = 32'h8000_0000;
            1: ra = 32'hFFFF_FFFF;
            2: ra = 32'h7FFF_FFFF;
            3: ra = $urandom_range(0, 200);
            default: ra = $urandom;
         endcase
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: rb = 32'hFFFF_FFFF;
            2: rb = 32'h8000_0000;
            3: rb = $urandom_range(1, 20);
            default: rb = $urandom;
         endcase
         if (ro == DIV && rb == 32'd0) ra[31] = 1'b0;
         bus.start = ($urandom_range(0, 3) == 0);
         bus.op    = ro;
         bus.a     = ra;
         bus.b     = rb;
         bus.hl_rd = $urandom_range(0, 1) == 1;
      end
      idle_inputs();
      repeat (40) @(posedge clk);
      checks++;
      if (nwrites < 100) begin
         errs++;
         $display("FAIL rand_writes: got %0d want >=100", nwrites);
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
